// File: rtl/and_reduce_arbiter_if.sv
// Request/operand/result bundle between requesters, consumer and the shared
// AND-reduction scheduler.
interface and_reduce_arbiter_if #(
    parameter int PORT_NUM = 2,
    parameter int WIDTH    = 8,
    parameter int IDW      = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1
);
    logic [PORT_NUM-1:0]       req;
    logic [PORT_NUM*3-1:0]     req_len;
    logic [PORT_NUM-1:0]       in_valid;
    logic [PORT_NUM*WIDTH-1:0] in_data;
    logic [PORT_NUM-1:0]       in_ready;
    logic [PORT_NUM-1:0]       grant;
    logic                      out_valid;
    logic [WIDTH-1:0]          out_data;
    logic [IDW-1:0]            out_id;
    logic                      out_ready;
    logic                      busy;

    modport slave (
        input  req, req_len, in_valid, in_data, out_ready,
        output in_ready, grant, out_valid, out_data, out_id, busy
    );

    modport master (
        output req, req_len, in_valid, in_data, out_ready,
        input  in_ready, grant, out_valid, out_data, out_id, busy
    );
endinterface

// File: rtl/and_reduce_arbiter.sv
// Round-robin scheduler time-sharing one AND-reduction accumulator among
// PORT_NUM requesters; each burst of 1..8 operands yields one tagged result.
module and_reduce_arbiter #(
    parameter int PORT_NUM = 2,
    parameter int WIDTH    = 8,
    parameter int IDW      = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    and_reduce_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]     owner_q, owner_d;
    logic [2:0]         len_q, len_d;
    logic [2:0]         cnt_q, cnt_d;
    logic [WIDTH-1:0]   acc_q, acc_d;

    logic                pick_found_s;
    logic [IDW-1:0]      pick_id_s;
    logic [PORT_NUM-1:0] pick_oh_s;
    logic [2:0]          pick_len_s;
    logic [PORT_NUM-1:0] owner_oh_s;
    logic [WIDTH-1:0]    sel_data_s;
    logic                accept_s;
    logic [IDW-1:0]      rr_next_s;

    // Round-robin pick: first requesting port at or above rr_ptr, wrapping.
    always_comb begin
        int idx_v;
        pick_found_s = 1'b0;
        pick_id_s    = '0;
        for (int k = 0; k < PORT_NUM; k++) begin
            idx_v = (int'(rr_ptr_q) + k) % PORT_NUM;
            if (!pick_found_s && bus.req[idx_v]) begin
                pick_found_s = 1'b1;
                pick_id_s    = IDW'(idx_v);
            end else begin
                pick_found_s = pick_found_s;
            end
        end
    end

    // One-hot decodes and AND-OR muxes for the picked/owning port.
    always_comb begin
        pick_len_s = 3'd0;
        sel_data_s = '0;
        for (int p = 0; p < PORT_NUM; p++) begin
            pick_oh_s[p]  = pick_found_s && (pick_id_s == IDW'(p));
            owner_oh_s[p] = (owner_q == IDW'(p));
            pick_len_s    = pick_len_s | ({3{pick_oh_s[p]}} & bus.req_len[p*3 +: 3]);
            sel_data_s    = sel_data_s | ({WIDTH{owner_oh_s[p]}} & bus.in_data[p*WIDTH +: WIDTH]);
        end
    end

    assign accept_s  = (state_q == S_ACCUM) && (|(bus.in_valid & owner_oh_s));
    assign rr_next_s = ((int'(owner_q) + 1) >= PORT_NUM) ? '0 : (owner_q + IDW'(1));

    // Next-state logic for the IDLE -> ACCUM -> DONE burst sequence.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        case (state_q)
            S_IDLE: begin
                if (pick_found_s) begin
                    owner_d = pick_id_s;
                    len_d   = pick_len_s;
                    acc_d   = '1;
                    cnt_d   = 3'd0;
                    state_d = S_ACCUM;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACCUM: begin
                if (accept_s) begin
                    acc_d = acc_q & sel_data_s;
                    cnt_d = cnt_q + 3'd1;
                    // Compare before increment so len=7 ends on the 8th accept.
                    if (cnt_q == len_q) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ACCUM;
                    end
                end else begin
                    state_d = S_ACCUM;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    rr_ptr_d = rr_next_s;
                    state_d  = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register with synchronous reset discarding any partial burst.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            len_q    <= 3'd0;
            cnt_q    <= 3'd0;
            acc_q    <= '1;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
        end
    end

    // Outputs depend on registered state only.
    assign bus.grant     = (state_q != S_IDLE)  ? owner_oh_s : '0;
    assign bus.in_ready  = (state_q == S_ACCUM) ? owner_oh_s : '0;
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.out_data  = (state_q == S_DONE)  ? acc_q : '0;
    assign bus.out_id    = (state_q == S_DONE)  ? owner_q : '0;
    assign bus.busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_and_reduce_arbiter.sv
// Directed and randomized bursts checked against a transaction-level model of
// round-robin arbitration and burst AND reduction.
module tb_and_reduce_arbiter;
    localparam int P  = 2;
    localparam int W  = 8;
    localparam int IW = 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    and_reduce_arbiter_if #(.PORT_NUM(P), .WIDTH(W), .IDW(IW)) bus ();

    and_reduce_arbiter #(.PORT_NUM(P), .WIDTH(W), .IDW(IW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int model_rr = 0;
    logic [W-1:0] ops [8];

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [P-1:0] r, input int rr);
        for (int k = 0; k < P; k++) begin
            if (r[(rr + k) % P]) return (rr + k) % P;
        end
        return 0;
    endfunction

    function automatic logic [P-1:0] oh(input int i);
        logic [P-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_busy"},      32'(bus.busy),      32'd0);
        check({tag, "_grant"},     32'(bus.grant),     32'd0);
        check({tag, "_in_ready"},  32'(bus.in_ready),  32'd0);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_out_data"},  32'(bus.out_data),  32'd0);
        check({tag, "_out_id"},    32'(bus.out_id),    32'd0);
    endtask

    // gap_mode: 0 back-to-back, 1 one idle cycle after first operand, 2 random gaps
    task automatic run_burst(input logic [P-1:0] reqv, input logic [3*P-1:0] lens,
                             input int bp, input int gap_mode, input bit junk);
        int w, len, k, cyc;
        bit v, gapped;
        logic [W-1:0] exp_and;
        w   = pick(reqv, model_rr);
        len = int'(lens[3*w +: 3]);
        exp_and = '1;
        for (int i = 0; i <= len; i++) exp_and = exp_and & ops[i];

        bus.req       = reqv;
        bus.req_len   = lens;
        bus.out_ready = 1'b0;
        bus.in_valid  = '0;
        tick();
        check("grant_start", 32'(bus.grant), 32'(oh(w)));
        check("busy_start",  32'(bus.busy),  32'd1);

        k = 0; cyc = 0; gapped = 1'b0;
        while (k <= len && cyc < 64) begin
            v = 1'b1;
            if (gap_mode == 1 && k == 1 && !gapped) begin
                v = 1'b0;
                gapped = 1'b1;
            end else if (gap_mode == 2) begin
                v = ($urandom_range(3) != 0);
            end
            for (int p = 0; p < P; p++) begin
                bus.in_valid[p] = (p == w) ? v : junk;
                bus.in_data[p*W +: W] = (p == w) ? ops[k] : '0;
            end
            check("in_ready_accum", 32'(bus.in_ready), 32'(oh(w)));
            if (v) k++;
            cyc++;
            tick();
        end
        check("accum_bound", 32'(k), 32'(len + 1));

        // Keep offering zero operands during DONE; any accept would corrupt the result.
        bus.in_valid = oh(w) | (junk ? '1 : '0);
        bus.in_data  = '0;
        check("done_in_ready",  32'(bus.in_ready),  32'd0);
        check("done_out_valid", 32'(bus.out_valid), 32'd1);
        check("done_out_data",  32'(bus.out_data),  32'(exp_and));
        check("done_out_id",    32'(bus.out_id),    32'(w));
        check("done_grant",     32'(bus.grant),     32'(oh(w)));
        for (int i = 0; i < bp; i++) begin
            tick();
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check("bp_out_data",  32'(bus.out_data),  32'(exp_and));
            check("bp_out_id",    32'(bus.out_id),    32'(w));
            check("bp_grant",     32'(bus.grant),     32'(oh(w)));
            check("bp_in_ready",  32'(bus.in_ready),  32'd0);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        bus.in_valid  = '0;
        bus.req       = '0;
        check_idle("after_consume");
        model_rr = (w + 1) % P;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        model_rr = 0;
    endtask

    initial begin
        logic [P-1:0]   rq;
        logic [3*P-1:0] ln;
        bus.req = '0; bus.req_len = '0; bus.in_valid = '0; bus.in_data = '0;
        bus.out_ready = 1'b0;
        do_reset();
        check_idle("reset");

        // Single-operand burst on port 0
        ops[0] = 8'h5A;
        run_burst(2'b01, 6'o00, 0, 0, 1'b0);

        // Eight-operand burst on port 1
        ops[0] = 8'hFF; ops[1] = 8'hFE; ops[2] = 8'hFD; ops[3] = 8'hFB;
        ops[4] = 8'hF7; ops[5] = 8'hEF; ops[6] = 8'hDF; ops[7] = 8'hBF;
        run_burst(2'b10, 6'o70, 0, 0, 1'b0);

        // Alternation with both ports requesting continuously
        do_reset();
        ops[0] = 8'h0F; ops[1] = 8'h3C;
        for (int i = 0; i < 4; i++) begin
            check("alt_expected_id", 32'(pick(2'b11, model_rr)), 32'(i % 2));
            run_burst(2'b11, 6'o11, 0, 0, 1'b0);
        end

        // Gap on owner, port 1 streaming zeros throughout
        ops[0] = 8'hF0; ops[1] = 8'hAA;
        run_burst(2'b01, 6'o01, 0, 1, 1'b1);

        // Five cycles of backpressure with both requesting
        ops[0] = 8'hC3; ops[1] = 8'h7E;
        run_burst(2'b11, 6'o11, 5, 0, 1'b1);

        // Reset mid-burst
        bus.req = 2'b01; bus.req_len = 6'o03;
        tick();
        check("mid_grant", 32'(bus.grant), 32'd1);
        bus.in_valid = 2'b01; bus.in_data = {8'h00, 8'h0F};
        tick();
        bus.in_data = {8'h00, 8'hF0};
        tick();
        reset = 1'b1; bus.in_valid = '0; bus.req = '0;
        tick();
        check_idle("mid_reset");
        reset = 1'b0;
        model_rr = 0;
        tick();
        check("post_reset_out_valid", 32'(bus.out_valid), 32'd0);
        ops[0] = 8'h33;
        run_burst(2'b01, 6'o00, 0, 0, 1'b0);

        // Randomized bursts
        for (int t = 0; t < 40; t++) begin
            rq = P'($urandom_range(1, (1 << P) - 1));
            ln = (3*P)'($urandom);
            for (int i = 0; i < 8; i++) ops[i] = W'($urandom);
            run_burst(rq, ln, $urandom_range(3), 2, 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/and_reduce_arbiter.md
# and_reduce_arbiter

Round-robin scheduler that shares one sequential bitwise-AND reduction unit among `PORT_NUM` requesters. Each requester wins a grant, streams a burst of 1–8 operands, and receives the AND of its burst tagged with its port id. It sits in front of the multi-operand AND datapath and replaces per-requester 8-input AND instances with a single time-shared accumulator.

## Interface
- `PORT_NUM`, 2: number of requesting ports (≥1).
- `WIDTH`, 8: operand/result width in bits.
- `IDW`, `PORT_NUM>1 ? $clog2(PORT_NUM) : 1`: id width (derived).

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: synchronous, active-high.
- `req` in PORT_NUM: bit p = port p requests a burst.
- `req_len` in PORT_NUM*3: port p field `[3p+:3]`; value L means L+1 operands (1..8).
- `in_valid` in PORT_NUM: bit p = port p operand valid.
- `in_data` in PORT_NUM*WIDTH: port p operand at `[p*WIDTH+:WIDTH]`.
- `in_ready` out PORT_NUM: operand accepted on port p when `in_valid[p] & in_ready[p]`.
- `grant` out PORT_NUM: one-hot, current burst owner; 0 when idle.
- `out_valid` out 1: result available.
- `out_data` out WIDTH: AND of burst; 0 when `out_valid`=0.
- `out_id` out IDW: port index of result; 0 when `out_valid`=0.
- `out_ready` in 1: consumer accepts result.
- `busy` out 1: state ≠ IDLE.

## Operation
- States: IDLE, ACCUM, DONE. Registers: `state`, `rr_ptr` (IDW), `owner` (IDW), `len` (3b), `cnt` (3b), `acc` (WIDTH).
- IDLE: if `req`≠0, select first set bit scanning from `rr_ptr` upward with wrap; latch `owner`, `len`=`req_len` field of owner; `acc`<=all ones; `cnt`<=0; go ACCUM. If `req`=0, stay.
- ACCUM: `grant[owner]`=1, `in_ready[owner]`=1, all other `in_ready`=0. On accept: `acc`<=`acc & in_data[owner]`, `cnt`<=`cnt+1`; if `cnt==len` at accept, go DONE. No accept → hold.
- DONE: `out_valid`=1, `out_data`=`acc`, `out_id`=`owner`, `grant[owner]` stays 1, all `in_ready`=0. On `out_ready`: `rr_ptr`<=(`owner`+1) mod `PORT_NUM`, go IDLE.
- `req` and `req_len` sampled only in IDLE; deasserting `req` during ACCUM/DONE does not abort the burst.
- `in_valid` on non-granted ports ignored; their data never reaches `acc`.
- `cnt`/`len` never wrap: len=7 completes exactly on 8th accept.
- Reset (any state, including mid-burst): `state`=IDLE, `rr_ptr`=0, `owner`=0, `cnt`=0, `len`=0, `acc`=all ones; outputs `grant`=0, `in_ready`=0, `out_valid`=0, `out_data`=0, `out_id`=0, `busy`=0. Partial burst discarded; no result emitted.

## Timing
- `in_ready`, `grant`, `out_*`, `busy` are decoded from registered state only; no combinational path from any input to any output.
- Request seen in IDLE at cycle N → `grant`/`in_ready` high from cycle N+1.
- Back-to-back operands: one accept per cycle; last of L+1 accepted at N+1+L; `out_valid` high at N+2+L.
- `out_valid` with `out_ready` at cycle M → IDLE at M+1; next grant no earlier than M+2. Minimum burst turnaround = L+4 cycles.
- Backpressure: while `out_ready`=0 in DONE, `out_valid`, `out_data`, `out_id`, `grant` held stable, no operand accepted, no new arbitration.
- Fairness: a port with `req` held continuously is granted within `PORT_NUM` arbitrations.

## Test plan
- Port 0, `req_len`=0, operand 0x5A at grant cycle, `out_ready`=1 → `out_valid` one cycle after accept, `out_data`=0x5A, `out_id`=0, IDLE next cycle.
- Port 1, `req_len`=7, operands 0xFF,0xFE,0xFD,0xFB,0xF7,0xEF,0xDF,0xBF back-to-back → exactly 8 accepts, `out_data`=0x80, `out_id`=1, `in_ready[1]` low after 8th.
- From reset, both ports `req`=1 continuously, `req_len`=1 each, operands 0x0F,0x3C → result ids in order 0,1,0,1, each `out_data`=0x0C.
- Port 0 granted, port 1 drives `in_valid`=1 `in_data`=0x00 throughout; port 0 sends 0xF0,0xAA with one-cycle `in_valid` gap → `out_data`=0xA0, `in_ready[1]`=0 always, 3 cycles in ACCUM.
- DONE with `out_ready`=0 for 5 cycles while both `req` high → `out_valid`, `out_data`, `out_id`, `grant` stable, `in_ready`=0; accept on 6th cycle, new grant 2 cycles later.
- Port 0 `req_len`=3, `reset` pulsed after 2 accepts → next cycle all outputs 0, no `out_valid`; subsequent port 0 burst 0x33 (`req_len`=0) → `out_data`=0x33 (acc reinitialised to all ones).
